// File: rtl/spi_master_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spi_master_arbiter                                                     |
// | Two-requester round-robin front end for an SPI master control port.    |
// | Optional abort-on-timeout when SPI_ARB_TIMEOUT_EN is defined.          |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module spi_master_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] tx0,
    input  logic [7:0] tx1,
    input  logic [1:0] sel0,
    input  logic [1:0] sel1,
    output logic [1:0] ack,
    output logic [7:0] rx_data,
    output logic [1:0] err,
    output logic [7:0] m_toXmit,
    output logic       m_strobe,
    output logic [1:0] m_ss,
    input  logic [7:0] m_Rcvd,
    input  logic       m_Ready,
    input  logic       m_XmitFull,
    input  logic       m_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_id, w_id_nxt;
    logic       r_last, w_last_nxt;
    logic       w_grant;
    logic [1:0] w_elig;
    logic [7:0] w_toxmit_nxt, w_rx_nxt;
    logic       w_strobe_nxt;
    logic [1:0] w_ss_nxt, w_ack_nxt;

    // Zero-cycle timeout is meaningless; parameter kept referenced in every build.
    if (TIMEOUT_CYCLES < 1) begin : g_param_guard
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_err, w_err_nxt;
    logic               w_timeout;

    assign w_timeout = (r_state != S_IDLE) &&
                       (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
    assign err       = r_err;
`else
    assign err = 2'b00;
`endif

    // A requester is not re-eligible during its own ack cycle.
    assign w_elig[0] = req[0] && (sel0 != 2'b00) && !ack[0];
    assign w_elig[1] = req[1] && (sel1 != 2'b00) && !ack[1];
    assign w_grant   = (w_elig == 2'b11) ? ~r_last : w_elig[1];

    always_comb begin
        w_state_nxt  = r_state;
        w_id_nxt     = r_id;
        w_last_nxt   = r_last;
        w_toxmit_nxt = m_toXmit;
        w_rx_nxt     = rx_data;
        w_strobe_nxt = 1'b0;
        w_ss_nxt     = m_ss;
        w_ack_nxt    = 2'b00;
`ifdef SPI_ARB_TIMEOUT_EN
        w_err_nxt    = 2'b00;
`endif
        case (r_state)
            S_IDLE: begin
                w_ss_nxt = 2'b00;
                if (|w_elig) begin
                    w_id_nxt     = w_grant;
                    w_toxmit_nxt = w_grant ? tx1 : tx0;
                    w_ss_nxt     = w_grant ? sel1 : sel0;
                    w_state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef SPI_ARB_TIMEOUT_EN
                if (w_timeout) begin
                    w_ack_nxt   = r_id ? 2'b10 : 2'b01;
                    w_err_nxt   = r_id ? 2'b10 : 2'b01;
                    w_rx_nxt    = 8'hFF;
                    w_ss_nxt    = 2'b00;
                    w_last_nxt  = r_id;
                    w_state_nxt = S_IDLE;
                end else
`endif
                if (!m_busy && !m_XmitFull) begin
                    w_strobe_nxt = 1'b1;
                    w_state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                // Completion wins over a coincident timeout.
                if (m_Ready) begin
                    w_ack_nxt   = r_id ? 2'b10 : 2'b01;
                    w_rx_nxt    = m_Rcvd;
                    w_ss_nxt    = 2'b00;
                    w_last_nxt  = r_id;
                    w_state_nxt = S_IDLE;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (w_timeout) begin
                    w_ack_nxt   = r_id ? 2'b10 : 2'b01;
                    w_err_nxt   = r_id ? 2'b10 : 2'b01;
                    w_rx_nxt    = 8'hFF;
                    w_ss_nxt    = 2'b00;
                    w_last_nxt  = r_id;
                    w_state_nxt = S_IDLE;
                end
`endif
            end
            default: begin
                w_ss_nxt    = 2'b00;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // r_last resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_id     <= 1'b0;
            r_last   <= 1'b1;
            m_toXmit <= 8'h00;
            m_strobe <= 1'b0;
            m_ss     <= 2'b00;
            ack      <= 2'b00;
            rx_data  <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_id     <= w_id_nxt;
            r_last   <= w_last_nxt;
            m_toXmit <= w_toxmit_nxt;
            m_strobe <= w_strobe_nxt;
            m_ss     <= w_ss_nxt;
            ack      <= w_ack_nxt;
            rx_data  <= w_rx_nxt;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 2'b00;
        end else begin
            r_err <= w_err_nxt;
            if (r_state == S_IDLE)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end
`endif

endmodule
`default_nettype wire
